// File: rtl/prn_serializer.sv
// Fetches a burst of PRN words from the 16-bit generator.
// Ports: clk/reset; start+num_words request; abort cancels;
// prn_in/lfsr_enable to the generator; bit_out/bit_valid/bit_ready
// serial MSB-first stream; busy during burst; done pulse at end.
module prn_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic [WIDTH-1:0] prn_in,
  output logic             lfsr_enable,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    lfsr_enable = 1'b0;
    bit_valid   = 1'b0;
    bit_out     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            wcnt_d  = num_words;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // Generator steps now; prn_in still holds the pre-step word.
        lfsr_enable = 1'b1;
        busy        = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          shreg_d = prn_in;
          bcnt_d  = BW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shreg_q[WIDTH-1];
        busy      = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (bit_ready) begin
          if (bcnt_q != '0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            bcnt_d  = bcnt_q - 1'b1;
          end else begin
            wcnt_d  = wcnt_q - 1'b1;
            state_d = (wcnt_q == CNT_W'(1)) ? DONE : LOAD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prn_serializer.sv
// Bench for prn_serializer with an attached 16-bit Galois LFSR
// (x^16+x^5+x^3+x^2+1, reset word 0xFFFF) and a bit-queue model.
module tb_prn_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_words;
  logic        abort;
  logic [15:0] prn;
  logic        lfsr_enable;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mword;

  prn_serializer #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_words(num_words),
    .abort(abort),
    .prn_in(prn),
    .lfsr_enable(lfsr_enable),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], 1'b0} ^ (v[15] ? 16'h002D : 16'h0000);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) prn <= 16'hFFFF;
    else if (lfsr_enable) prn <= lfsr_next(prn);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, {31'd0, lfsr_enable}, 0);
    chk({tag, "_bout"}, {31'd0, bit_out}, 0);
    chk({tag, "_bvalid"}, {31'd0, bit_valid}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // rmode: 0 ready held 1, 1 toggling 1,0,..., 2 random
  task automatic burst(input int n, input int rmode, input bit inj);
    logic q[$];
    logic [15:0] w;
    int en, cyc, dcyc, lastacc;
    w = mword;
    for (int k = 0; k < n; k++) begin
      for (int b = 15; b >= 0; b--) q.push_back(w[b]);
      w = lfsr_next(w);
    end
    mword = w;
    en = 0;
    dcyc = -1;
    lastacc = -1;
    start = 1'b1;
    num_words = 8'(n);
    bit_ready = 1'b1;
    tick();
    start = 1'b0;
    num_words = 8'd0;
    cyc = 1;
    while (cyc < 3000) begin
      case (rmode)
        0: bit_ready = 1'b1;
        1: bit_ready = (cyc % 2 == 0);
        default: bit_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj && cyc == 6) begin
        start = 1'b1;
        num_words = 8'd7;
      end else begin
        start = 1'b0;
        num_words = 8'd0;
      end
      if (lfsr_enable) en++;
      if (bit_valid) begin
        if (q.size() != 0) chk("bit", {31'd0, bit_out}, {31'd0, q[0]});
        else chk("extra_bit", {31'd0, bit_valid}, 0);
        if (bit_ready && q.size() != 0) begin
          void'(q.pop_front());
          lastacc = cyc;
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, ~done});
      if (done) begin
        dcyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("bits_left", q.size(), 0);
    chk("lfsr_steps", en, n);
    chk("done_seen", {31'd0, dcyc >= 0}, 1);
    if (rmode == 0) chk("done_cycle", dcyc, n * 17 + 1);
    if (n > 0) chk("done_after_last", dcyc, lastacc + 1);
    tick();
    chk_idle("post");
  endtask

  initial begin
    int acc;
    reset = 1'b1;
    start = 1'b0;
    num_words = 8'd0;
    abort = 1'b0;
    bit_ready = 1'b0;
    mword = 16'hFFFF;
    tick();
    chk_idle("reset");
    tick();
    reset = 1'b0;
    tick();

    burst(2, 0, 1'b0);
    burst(1, 1, 1'b0);
    burst(0, 0, 1'b0);
    burst(2, 0, 1'b1);

    // Abort after 5 bits of word 1 of 3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mword = 16'hFFFF;
    tick();
    start = 1'b1;
    num_words = 8'd3;
    bit_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_load_en", {31'd0, lfsr_enable}, 1);
    acc = 0;
    for (int c = 0; c < 40 && acc < 5; c++) begin
      tick();
      if (bit_valid) begin
        chk("abort_bit", {31'd0, bit_out}, {31'd0, mword[15 - acc]});
        acc++;
      end
    end
    tick();
    abort = 1'b1;
    chk("abort_valid", {31'd0, bit_valid}, 1);
    tick();
    abort = 1'b0;
    chk_idle("abort");
    tick();
    chk("abort_no_done", {31'd0, done}, 0);
    mword = lfsr_next(mword);
    burst(1, 0, 1'b0);

    // Asynchronous reset mid-SHIFT.
    start = 1'b1;
    num_words = 8'd2;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("pre_reset_valid", {31'd0, bit_valid}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_reset");
    tick();
    reset = 1'b0;
    mword = 16'hFFFF;
    tick();
    chk_idle("after_reset");
    burst(1, 0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      burst(int'($urandom_range(0, 4)), 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
